// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: two-stage valid/ready shift/rotate unit for the ALU shifter path.
//
// Modes (mode): 0=LSL, 1=LSR, 2=ASR, 3=ROR, 4=ROL, 5-7 illegal (passes inp through, err=1).
// The whole shift_value operand is significant. Amounts >= WIDTH saturate for the
// shifts, and rotates use shift_value mod WIDTH.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active-low
//   in_valid     operands valid
//   in_ready     unit can accept operands this cycle
//   inp          operand to shift
//   shift_value  unsigned shift amount
//   mode         operation select
//   out_valid    result valid
//   out_ready    consumer accepts result
//   out          shifted result
//   cout         last bit shifted/rotated out
//   zf           out == 0
//   nf           out[WIDTH-1]
//   err          illegal mode for this result
//
// S1 registers the operands. The shifter works combinationally on S1, and S2 registers
// the result and flags, which drive the outputs directly.

module shift_unit_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp,
    input  logic [SHW-1:0]   shift_value,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             zf,
    output logic             nf,
    output logic             err
);

    localparam int unsigned    LW   = $clog2(WIDTH);
    localparam logic [SHW-1:0] WVAL = SHW'(WIDTH);

    typedef enum logic [2:0] {
        ModeLsl = 3'd0,
        ModeLsr = 3'd1,
        ModeAsr = 3'd2,
        ModeRor = 3'd3,
        ModeRol = 3'd4
    } mode_e;

    // Stage 1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_inp_q;
    logic [SHW-1:0]   s1_n_q;
    logic [2:0]       s1_mode_q;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = !s1_valid_q | s2_adv;
    assign in_ready = rst & s1_adv;

    // Shifter datapath on the S1 operands
    logic [LW-1:0]      amt;
    logic               n_zero;
    logic               n_lt_w;
    logic               n_eq_w;
    logic               sign;
    logic [WIDTH:0]     lsl_ext;
    logic [WIDTH:0]     lsr_ext;
    logic [WIDTH-1:0]   asr_val;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] ror_full;
    logic [2*WIDTH-1:0] rol_full;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_e;

    assign amt    = s1_n_q[LW-1:0];
    assign n_zero = (s1_n_q == '0);
    assign n_lt_w = (s1_n_q < WVAL);
    assign n_eq_w = (s1_n_q == WVAL);
    assign sign   = s1_inp_q[WIDTH-1];

    // One guard bit on each side catches the bit that leaves for amounts below WIDTH.
    assign lsl_ext  = {1'b0, s1_inp_q} << amt;
    assign lsr_ext  = {s1_inp_q, 1'b0} >> amt;
    assign asr_val  = $signed(s1_inp_q) >>> amt;
    assign dbl      = {s1_inp_q, s1_inp_q};
    assign ror_full = dbl >> amt;
    assign rol_full = dbl << amt;

    always_comb begin
        res   = s1_inp_q;
        res_c = 1'b0;
        res_e = 1'b0;
        case (s1_mode_q)
            ModeLsl: begin
                res = n_lt_w ? lsl_ext[WIDTH-1:0] : '0;
                if (n_zero)      res_c = 1'b0;
                else if (n_lt_w) res_c = lsl_ext[WIDTH];
                else if (n_eq_w) res_c = s1_inp_q[0];
                else             res_c = 1'b0;
            end
            ModeLsr: begin
                res = n_lt_w ? lsr_ext[WIDTH:1] : '0;
                if (n_zero)      res_c = 1'b0;
                else if (n_lt_w) res_c = lsr_ext[0];
                else if (n_eq_w) res_c = sign;
                else             res_c = 1'b0;
            end
            ModeAsr: begin
                res = n_lt_w ? asr_val : {WIDTH{sign}};
                if (n_zero)      res_c = 1'b0;
                else if (n_lt_w) res_c = lsr_ext[0];
                else             res_c = sign;
            end
            ModeRor: begin
                res   = ror_full[WIDTH-1:0];
                res_c = !n_zero & res[WIDTH-1];
            end
            ModeRol: begin
                res   = rol_full[2*WIDTH-1:WIDTH];
                res_c = !n_zero & res[0];
            end
            default: begin
                res   = s1_inp_q;
                res_c = 1'b0;
                res_e = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_inp_q   <= '0;
            s1_n_q     <= '0;
            s1_mode_q  <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid & in_ready;
            s1_inp_q   <= inp;
            s1_n_q     <= shift_value;
            s1_mode_q  <= mode;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            cout      <= 1'b0;
            zf        <= 1'b0;
            nf        <= 1'b0;
            err       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid_q;
            out       <= res;
            cout      <= res_c;
            zf        <= (res == '0);
            nf        <= res[WIDTH-1];
            err       <= res_e;
        end
    end

endmodule

// File: doc/shift_unit_pipe.md
# shift_unit_pipe

- Parametrised, pipelined shift/rotate unit for the ALU shifter path.
- Supports five modes: LSL, LSR, ASR, ROR and ROL.
- Uses the full shift-amount operand with defined over-range behaviour, and produces carry/zero/negative flags.
- Two-stage valid/ready pipeline with full throughput and backpressure; it sits between operand fetch and the ALU result mux.

## Interface
- WIDTH, 16, data width in bits (≥2, power of two).
- SHW, 16, width of the shift_value operand (≥ log2(WIDTH)+1).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit can accept operands this cycle.
- inp  in  WIDTH  operand to shift.
- shift_value  in  SHW  unsigned shift amount, full width significant.
- mode  in  3  0=LSL, 1=LSR, 2=ASR, 3=ROR, 4=ROL, 5–7 illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  shifted result.
- cout  out  1  carry: last bit shifted/rotated out.
- zf  out  1  out == 0.
- nf  out  1  out[WIDTH-1].
- err  out  1  illegal mode for this result.

## Operation
Notation: n = shift_value, treated as unsigned; W = WIDTH.

Stage 1 (S1) registers inp, n, mode and s1_valid. Stage 2 (S2) registers out, the flags and out_valid.

Results by mode:
- LSL: n ≥ W gives out=0. Otherwise out = inp<<n.
- LSR: n ≥ W gives out=0. Otherwise out = inp>>n, zero fill.
- ASR: n ≥ W gives out = all copies of inp[W-1]. Otherwise out = inp>>n, sign fill.
- ROR / ROL: rotate by n mod W.

Carry (n=0 always gives cout=0):
- LSL: 1≤n≤W gives inp[W-n]; n>W gives 0.
- LSR: 1≤n≤W gives inp[n-1]; n>W gives 0.
- ASR: 1≤n≤W gives inp[n-1]; n>W gives inp[W-1].
- ROR: out[W-1].
- ROL: out[0].
- Note: ROR/ROL with n≠0 and n mod W = 0 gives out=inp, with cout taken as above.

Other flags:
- zf and nf are always derived from the final out.
- Illegal mode: out=inp, cout=0, err=1, flags computed normally. err=0 for legal modes.

Handshake:
- S2 advance: s2_adv = !out_valid | out_ready.
- S1 advance: s1_adv = !s1_valid | s2_adv.
- in_ready = rst & s1_adv. This is combinational, with no dependency on in_valid.
- Input transfer occurs on in_valid & in_ready. Output transfer occurs on out_valid & out_ready.
- When s2_adv, S2 loads the S1 result and out_valid ← s1_valid.
- When s1_adv, S1 loads the inputs and s1_valid ← in_valid & in_ready.
- When a stage does not advance, it holds every register unchanged. out and the flags are stable while out_valid & !out_ready.
- Results leave in acceptance order; no drop, no duplication.

## Timing
- Latency: exactly 2 cycles. An operand accepted at edge k has out_valid=1 after edge k+1, provided out_ready was high or S2 was empty.
- Throughput: one result per cycle while out_ready=1.
- Backpressure: with out_ready=0, at most 2 operations are held (S1 + S2). in_ready drops in the cycle both stages are full and out_ready=0.
- Reset asserted: immediately clears s1_valid, out_valid, out, cout, zf, nf, err and the S1 registers to 0. in_ready=0 while rst=0.
- Reset mid-operation: in-flight operations are discarded, not completed.
- First cycle after release: in_ready=1.
- Simultaneous input accept and output consume with both stages full: both transfers occur and the pipeline stays full.

## Test plan
All scenarios use WIDTH=16, SHW=16.
- Basic modes, one per cycle, out_ready=1:
  - LSL 0x0F00 by 4 → 0xF000, cout=0, nf=1.
  - ASR 0xFF80 by 3 → 0xFFF0, cout=0.
  - ROL 0x8001 by 1 → 0x0003, cout=1.
  - Each result has out_valid exactly 2 cycles after accept.
- Over-range amounts:
  - LSL 0x0030 by 17 → 0x0000, zf=1, cout=0.
  - LSR 0x8000 by 16 → 0x0000, cout=1.
  - ASR 0x8000 by 20 → 0xFFFF, cout=1.
  - ROR 0x0001 by 17 → 0x8000, cout=1.
  - ROR 0x1234 by 16 → 0x1234.
- Zero shift and illegal mode:
  - LSL 0xFFFF by 0 → 0xFFFF, cout=0.
  - mode=6, inp 0x00AB → out 0x00AB, err=1.
- Backpressure:
  - Hold out_ready=0, present 3 back-to-back ops (LSL 1 on 0x0001, 0x0002, 0x0003) → 2 accepted, in_ready=0 on the third.
  - Release out_ready → outputs 0x0002, 0x0004, 0x0006 in order, out stable while stalled.
- Reset mid-operation: assert rst with both stages full → out_valid=0 and out=0 immediately (asynchronous); after release, in_ready=1 and no stale result ever appears.
- Random streaming: random ops with random out_ready checked against a reference model → all results match, in order, with no loss.
